// File: rtl/ifc_mbox_slave.sv
// IFC local-bus mailbox slave: synchronised IFC strobes, NREG control registers,
// a status/command register and a pop-on-read FIFO data port for the CPLD.
module ifc_mbox_slave #(
   parameter int            DW        = 16,
   parameter int            AW        = 8,
   parameter int            NREG      = 4,
   parameter logic [AW-1:0] BASE_CTRL = 8'h10,
   parameter logic [AW-1:0] ADDR_STAT = 8'h40,
   parameter logic [AW-1:0] ADDR_DATA = 8'h54,
   parameter int            FIFO_AW   = 4,
   parameter int            IRQ_LEVEL = 5,
   parameter bit            BIT_REV   = 1'b1
) (
   input  logic                 clock_50MHz,
   input  logic                 rst_n,
   input  logic                 ifc_cs,
   input  logic                 ifc_we_b,
   input  logic                 ifc_oe_b,
   input  logic                 ifc_avd,
   input  logic [AW-1:0]        ifc_addr,
   input  logic [DW-1:0]        ifc_ad_i,
   output logic [DW-1:0]        ifc_ad_o,
   output logic                 ifc_ad_oe,
   input  logic [DW-1:0]        fill_data,
   input  logic                 fill_valid,
   output logic                 fill_ready,
   output logic [NREG*DW-1:0]   reg_q,
   output logic [NREG-1:0]      reg_wr,
   output logic                 blk_req,
   output logic [FIFO_AW:0]     fifo_cnt,
   output logic                 irq
);
   localparam int               DEPTH    = 1 << FIFO_AW;
   localparam int               IW       = (NREG > 1) ? $clog2(NREG) : 1;
   localparam logic [FIFO_AW:0] FULL_CNT = {1'b1, {FIFO_AW{1'b0}}};
   localparam logic [FIFO_AW:0] IRQ_CNT  = (FIFO_AW+1)'(IRQ_LEVEL);

   function automatic logic [DW-1:0] rev_data(input logic [DW-1:0] d);
      logic [DW-1:0] r;
      for (int i = 0; i < DW; i++) r[i] = BIT_REV ? d[DW-1-i] : d[i];
      return r;
   endfunction

   function automatic logic [AW-1:0] rev_addr(input logic [AW-1:0] a);
      logic [AW-1:0] r;
      for (int i = 0; i < AW; i++) r[i] = BIT_REV ? a[AW-1-i] : a[i];
      return r;
   endfunction

   logic [2:0]         cs_sync_r, we_sync_r, oe_sync_r, avd_sync_r;
   logic [DW-1:0]      ad_r, ad_d_r, wdata_r, wdata_rev_s;
   logic [AW-1:0]      addr_r;
   logic               avd_fall_s, we_rise_s, oe_rise_s, rd_active_s;
   logic               ctrl_hit_s, stat_wr_s, blk_s, clr_s, flush_s, pop_evt_s;
   logic [IW-1:0]      ctrl_idx_s;
   logic [NREG-1:0]    reg_hit_s;
   logic [NREG*DW-1:0] reg_q_r;
   logic [NREG-1:0]    reg_wr_r;
   logic               blk_req_r;
   logic [DW-1:0]      mem_r [DEPTH];
   logic [FIFO_AW-1:0] wptr_r, rptr_r, wptr_next_s, rptr_next_s;
   logic [FIFO_AW:0]   cnt_r, cnt_next_s;
   logic               empty_s, full_s, pop_ok_s, push_ok_s, ovf_set_s, unf_set_s;
   logic               ovf_r, unf_r, ovf_next_s, unf_next_s;
   logic               fill_ready_r, irq_r;
   logic [DW-1:0]      stat_word_s, rd_mux_s, ad_o_r;
   logic               ad_oe_r;

   // Strobe synchronisers; stage [2] is the previous synced sample for edge detection
   always_ff @(posedge clock_50MHz or negedge rst_n) begin
      if (!rst_n) begin
         cs_sync_r  <= 3'b111;
         we_sync_r  <= 3'b111;
         oe_sync_r  <= 3'b111;
         avd_sync_r <= 3'b000;
      end else begin
         cs_sync_r  <= {cs_sync_r[1:0],  ifc_cs};
         we_sync_r  <= {we_sync_r[1:0],  ifc_we_b};
         oe_sync_r  <= {oe_sync_r[1:0],  ifc_oe_b};
         avd_sync_r <= {avd_sync_r[1:0], ifc_avd};
      end
   end

   assign avd_fall_s  = avd_sync_r[2] & ~avd_sync_r[1];
   assign we_rise_s   = we_sync_r[1] & ~we_sync_r[2] & ~cs_sync_r[2];
   assign oe_rise_s   = oe_sync_r[1] & ~oe_sync_r[2] & ~cs_sync_r[2];
   assign rd_active_s = ~cs_sync_r[1] & ~oe_sync_r[1];

   // AD bus capture; the second stage lines the data up with the synced we_b
   always_ff @(posedge clock_50MHz or negedge rst_n) begin
      if (!rst_n) begin
         ad_r    <= '0;
         ad_d_r  <= '0;
         wdata_r <= '0;
         addr_r  <= '0;
      end else begin
         ad_r    <= ifc_ad_i;
         ad_d_r  <= ad_r;
         wdata_r <= we_sync_r[1] ? wdata_r : ad_d_r;
         addr_r  <= avd_fall_s ? rev_addr(ifc_addr) : addr_r;
      end
   end

   assign wdata_rev_s = rev_data(wdata_r);
   assign stat_wr_s   = we_rise_s & (addr_r == ADDR_STAT);
   assign blk_s       = stat_wr_s & wdata_rev_s[0];
   assign clr_s       = stat_wr_s & wdata_rev_s[1];
   assign flush_s     = stat_wr_s & wdata_rev_s[2];
   assign pop_evt_s   = oe_rise_s & (addr_r == ADDR_DATA);

   // Control-register address decode
   always_comb begin
      ctrl_hit_s = 1'b0;
      ctrl_idx_s = '0;
      reg_hit_s  = '0;
      for (int k = 0; k < NREG; k++) begin
         if (addr_r == BASE_CTRL + AW'(k)) begin
            ctrl_hit_s   = 1'b1;
            ctrl_idx_s   = IW'(k);
            reg_hit_s[k] = we_rise_s;
         end else begin
            reg_hit_s[k] = 1'b0;
         end
      end
   end

   // Control registers and command pulses
   always_ff @(posedge clock_50MHz or negedge rst_n) begin
      if (!rst_n) begin
         reg_q_r   <= '0;
         reg_wr_r  <= '0;
         blk_req_r <= 1'b0;
      end else begin
         for (int k = 0; k < NREG; k++) begin
            if (reg_hit_s[k]) reg_q_r[k*DW +: DW] <= wdata_rev_s;
         end
         reg_wr_r  <= reg_hit_s;
         blk_req_r <= blk_s;
      end
   end

   assign empty_s = (cnt_r == '0);
   assign full_s  = (cnt_r == FULL_CNT);

   // FIFO next state; flush overrides push, and a pop frees a slot even when full
   always_comb begin
      pop_ok_s  = pop_evt_s & ~empty_s;
      unf_set_s = pop_evt_s & empty_s;
      push_ok_s = fill_valid & ~flush_s & (fill_ready_r | (full_s & pop_ok_s));
      ovf_set_s = fill_valid & ~flush_s & full_s & ~pop_ok_s;
      if (flush_s) begin
         cnt_next_s  = '0;
         wptr_next_s = '0;
         rptr_next_s = '0;
      end else begin
         cnt_next_s  = cnt_r + (FIFO_AW+1)'(push_ok_s) - (FIFO_AW+1)'(pop_ok_s);
         wptr_next_s = wptr_r + FIFO_AW'(push_ok_s);
         rptr_next_s = rptr_r + FIFO_AW'(pop_ok_s);
      end
      ovf_next_s = (ovf_r & ~clr_s) | ovf_set_s;
      unf_next_s = (unf_r & ~clr_s) | unf_set_s;
   end

   // FIFO state, sticky flags and derived outputs
   always_ff @(posedge clock_50MHz or negedge rst_n) begin
      if (!rst_n) begin
         cnt_r        <= '0;
         wptr_r       <= '0;
         rptr_r       <= '0;
         ovf_r        <= 1'b0;
         unf_r        <= 1'b0;
         fill_ready_r <= 1'b0;
         irq_r        <= 1'b0;
      end else begin
         cnt_r        <= cnt_next_s;
         wptr_r       <= wptr_next_s;
         rptr_r       <= rptr_next_s;
         ovf_r        <= ovf_next_s;
         unf_r        <= unf_next_s;
         fill_ready_r <= (cnt_next_s != FULL_CNT);
         irq_r        <= (cnt_next_s >= IRQ_CNT) | ovf_next_s | unf_next_s;
      end
   end

   // FIFO storage
   always_ff @(posedge clock_50MHz) begin
      if (push_ok_s) mem_r[wptr_r] <= fill_data;
   end

   // Read data mux in logical bit order
   always_comb begin
      stat_word_s            = '0;
      stat_word_s[FIFO_AW:0] = cnt_r;
      stat_word_s[DW-1]      = ovf_r;
      stat_word_s[DW-2]      = unf_r;
      case (addr_r)
         ADDR_STAT: rd_mux_s = stat_word_s;
         ADDR_DATA: rd_mux_s = empty_s ? '0 : mem_r[rptr_r];
         default:   rd_mux_s = ctrl_hit_s ? reg_q_r[ctrl_idx_s*DW +: DW] : '0;
      endcase
   end

   // Read drive: value frozen on the first synced read cycle so the bus stays stable
   always_ff @(posedge clock_50MHz or negedge rst_n) begin
      if (!rst_n) begin
         ad_oe_r <= 1'b0;
         ad_o_r  <= '0;
      end else begin
         ad_oe_r <= rd_active_s;
         if (rd_active_s && !ad_oe_r) ad_o_r <= rev_data(rd_mux_s);
      end
   end

   assign ifc_ad_o   = ad_o_r;
   assign ifc_ad_oe  = ad_oe_r;
   assign fill_ready = fill_ready_r;
   assign reg_q      = reg_q_r;
   assign reg_wr     = reg_wr_r;
   assign blk_req    = blk_req_r;
   assign fifo_cnt   = cnt_r;
   assign irq        = irq_r;
endmodule

// File: tb/tb_ifc_mbox_slave.sv
// Self-checking bench for ifc_mbox_slave: directed test-plan steps followed by a
// randomized bus/fill sequence, all checked against a queue-based mailbox model.
`timescale 1ns/1ps
module tb_ifc_mbox_slave;
   localparam int DW = 16, AW = 8, NREG = 4, FIFO_AW = 4, DEPTH = 16;

   logic                clock_50MHz = 1'b0;
   logic                rst_n, ifc_cs, ifc_we_b, ifc_oe_b, ifc_avd;
   logic [AW-1:0]       ifc_addr;
   logic [DW-1:0]       ifc_ad_i, ifc_ad_o, fill_data;
   logic                ifc_ad_oe, fill_valid, fill_ready, blk_req, irq;
   logic [NREG*DW-1:0]  reg_q;
   logic [NREG-1:0]     reg_wr;
   logic [FIFO_AW:0]    fifo_cnt;

   always #10 clock_50MHz = ~clock_50MHz;

   ifc_mbox_slave dut (
      .clock_50MHz(clock_50MHz), .rst_n(rst_n), .ifc_cs(ifc_cs), .ifc_we_b(ifc_we_b),
      .ifc_oe_b(ifc_oe_b), .ifc_avd(ifc_avd), .ifc_addr(ifc_addr), .ifc_ad_i(ifc_ad_i),
      .ifc_ad_o(ifc_ad_o), .ifc_ad_oe(ifc_ad_oe), .fill_data(fill_data),
      .fill_valid(fill_valid), .fill_ready(fill_ready), .reg_q(reg_q), .reg_wr(reg_wr),
      .blk_req(blk_req), .fifo_cnt(fifo_cnt), .irq(irq)
   );

   int checks = 0, errors = 0;
   int wr_pulses = 0, blk_pulses = 0;
   logic [NREG-1:0] wr_last = '0;

   // behavioural mailbox model
   logic [DW-1:0] m_regs [NREG];
   logic [DW-1:0] m_q [$];
   bit            m_ovf, m_unf;

   always @(negedge clock_50MHz) begin
      if (reg_wr != '0) begin
         wr_pulses++;
         wr_last = reg_wr;
      end
      if (blk_req) blk_pulses++;
   end

   function automatic logic [15:0] rev16(input logic [15:0] d);
      return {<<{d}};
   endfunction

   function automatic logic [7:0] rev8(input logic [7:0] a);
      return {<<{a}};
   endfunction

   function automatic logic [15:0] m_stat();
      return {m_ovf, m_unf, 9'b0, 5'(m_q.size())};
   endfunction

   function automatic logic m_irq();
      return (m_q.size() >= 5) || m_ovf || m_unf;
   endfunction

   function automatic logic [63:0] m_regq();
      return {m_regs[3], m_regs[2], m_regs[1], m_regs[0]};
   endfunction

   task automatic model_reset();
      for (int k = 0; k < NREG; k++) m_regs[k] = '0;
      m_q.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic wait_neg(input int n);
      repeat (n) @(negedge clock_50MHz);
   endtask

   task automatic chk_state(input string tag);
      chk({tag, "_cnt"}, 64'(fifo_cnt), 64'(m_q.size()));
      chk({tag, "_irq"}, 64'(irq), 64'(m_irq()));
      chk({tag, "_ready"}, 64'(fill_ready), 64'(m_q.size() < DEPTH));
   endtask

   task automatic addr_phase(input logic [AW-1:0] a);
      ifc_addr = rev8(a);
      ifc_avd  = 1'b1;
      wait_neg(2);
      ifc_avd  = 1'b0;
      wait_neg(4);
   endtask

   task automatic bus_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
      addr_phase(a);
      ifc_ad_i = rev16(d);
      ifc_cs   = 1'b0;
      ifc_we_b = 1'b0;
      wait_neg(4);
      ifc_we_b = 1'b1;
      ifc_cs   = 1'b1;
      wait_neg(5);
      for (int k = 0; k < NREG; k++) if (a == AW'(8'h10 + k)) m_regs[k] = d;
      if (a == 8'h40) begin
         if (d[1]) begin
            m_ovf = 1'b0;
            m_unf = 1'b0;
         end
         if (d[2]) m_q.delete();
      end
   endtask

   // read with optional fill push timed to land on the same clock as the pop
   task automatic bus_read(input logic [AW-1:0] a, input bit push_en,
                           input logic [DW-1:0] push_d, output logic [DW-1:0] raw);
      int            lat;
      logic [DW-1:0] first, exp;
      bit            was_full, popped;
      exp = '0;
      for (int k = 0; k < NREG; k++) if (a == AW'(8'h10 + k)) exp = m_regs[k];
      if (a == 8'h40) exp = m_stat();
      if (a == 8'h54 && m_q.size() > 0) exp = m_q[0];
      addr_phase(a);
      ifc_cs   = 1'b0;
      ifc_oe_b = 1'b0;
      lat = 0;
      while (ifc_ad_oe !== 1'b1 && lat < 8) begin
         wait_neg(1);
         lat++;
      end
      chk("rd_latency_ok", 64'(lat >= 2 && lat <= 3), 64'd1);
      first = ifc_ad_o;
      wait_neg(3);
      raw = ifc_ad_o;
      chk("rd_stable", 64'(raw), 64'(first));
      chk($sformatf("rd_data_%02h", a), 64'(rev16(raw)), 64'(exp));
      ifc_oe_b = 1'b1;
      ifc_cs   = 1'b1;
      if (push_en) begin
         wait_neg(2);
         fill_data  = push_d;
         fill_valid = 1'b1;
         wait_neg(1);
         fill_valid = 1'b0;
         wait_neg(2);
      end else begin
         wait_neg(5);
      end
      chk("rd_oe_release", 64'(ifc_ad_oe), 64'd0);
      was_full = (m_q.size() == DEPTH);
      popped   = 1'b0;
      if (a == 8'h54) begin
         if (m_q.size() > 0) begin
            void'(m_q.pop_front());
            popped = 1'b1;
         end else begin
            m_unf = 1'b1;
         end
      end
      if (push_en) begin
         if (!was_full || popped) m_q.push_back(push_d);
         else m_ovf = 1'b1;
      end
   endtask

   task automatic push(input logic [DW-1:0] d);
      chk("push_ready", 64'(fill_ready), 64'(m_q.size() < DEPTH));
      fill_data  = d;
      fill_valid = 1'b1;
      wait_neg(1);
      fill_valid = 1'b0;
      wait_neg(1);
      if (m_q.size() < DEPTH) m_q.push_back(d);
      else m_ovf = 1'b1;
   endtask

   initial begin
      logic [DW-1:0] raw, d;
      int            b0, w0, idx, op;

      rst_n = 1'b0; ifc_cs = 1'b1; ifc_we_b = 1'b1; ifc_oe_b = 1'b1; ifc_avd = 1'b0;
      ifc_addr = '0; ifc_ad_i = '0; fill_data = '0; fill_valid = 1'b0;
      model_reset();
      wait_neg(3);
      chk("reset_outputs", {ifc_ad_o, ifc_ad_oe, fill_ready, reg_wr, blk_req, fifo_cnt, irq}, 64'd0);
      chk("reset_regq", reg_q, 64'd0);
      rst_n = 1'b1;
      wait_neg(3);

      // status read right after reset
      bus_read(8'h40, 1'b0, '0, raw);
      chk("post_reset_irq", 64'(irq), 64'd0);

      // control register write and read-back
      w0 = wr_pulses;
      bus_write(8'h11, 16'h0123);
      chk("wr_pulse_count", 64'(wr_pulses - w0), 64'd1);
      chk("wr_pulse_bit", 64'(wr_last), 64'(4'b0010));
      chk("regq_after_wr", reg_q, m_regq());
      bus_read(8'h11, 1'b0, '0, raw);
      chk("rd_raw_bus_order", 64'(raw), 64'(16'hC480));

      // block request and FIFO ordering
      b0 = blk_pulses;
      bus_write(8'h40, 16'h0001);
      chk("blk_pulse", 64'(blk_pulses - b0), 64'd1);
      for (int i = 0; i < 5; i++) push(16'h1000 + 16'(i));
      chk_state("fill5");
      for (int i = 0; i < 5; i++) bus_read(8'h54, 1'b0, '0, raw);
      chk_state("drain5");

      // underflow and flag clear
      bus_read(8'h54, 1'b0, '0, raw);
      chk_state("underflow");
      bus_read(8'h40, 1'b0, '0, raw);
      bus_write(8'h40, 16'h0002);
      chk_state("clear_flags");

      // overflow, flush keeps ovf, push+pop at full
      for (int i = 0; i < 17; i++) push(16'h2000 + 16'(i));
      chk_state("overflow");
      bus_read(8'h40, 1'b0, '0, raw);
      bus_write(8'h40, 16'h0004);
      chk_state("flush");
      bus_read(8'h40, 1'b0, '0, raw);
      for (int i = 0; i < 16; i++) push(16'h3000 + 16'(i));
      bus_read(8'h54, 1'b1, 16'h3AAA, raw);
      chk_state("push_pop_full");
      bus_write(8'h40, 16'h0006);
      chk_state("flush_clear");

      // randomized traffic against the model
      for (int n = 0; n < 60; n++) begin
         op = $urandom_range(0, 9);
         d  = 16'($urandom);
         if (op <= 3) begin
            push(d);
         end else if (op <= 5) begin
            bus_read(8'h54, 1'($urandom_range(0, 1)), d, raw);
         end else if (op == 6) begin
            bus_read(8'h40, 1'b0, '0, raw);
         end else if (op == 7) begin
            idx = $urandom_range(0, NREG-1);
            w0  = wr_pulses;
            bus_write(AW'(8'h10 + idx), d);
            chk("rnd_wr_pulse", 64'(wr_pulses - w0), 64'd1);
            chk("rnd_wr_bit", 64'(wr_last), 64'(1 << idx));
            chk("rnd_regq", reg_q, m_regq());
            bus_read(AW'(8'h10 + idx), 1'b0, '0, raw);
         end else if (op == 8) begin
            b0 = blk_pulses;
            d  = 16'($urandom_range(0, 7));
            bus_write(8'h40, d);
            chk("rnd_blk", 64'(blk_pulses - b0), 64'(d[0]));
         end else begin
            bus_write(8'h20, d);
            bus_read(8'h20, 1'b0, '0, raw);
            chk("rnd_unmapped_regq", reg_q, m_regq());
         end
         chk_state("rnd");
      end

      // reset during an active read
      push(16'h4444);
      push(16'h5555);
      addr_phase(8'h11);
      ifc_cs   = 1'b0;
      ifc_oe_b = 1'b0;
      wait_neg(4);
      chk("pre_reset_oe", 64'(ifc_ad_oe), 64'd1);
      #3 rst_n = 1'b0;
      #1 chk("async_oe_drop", 64'(ifc_ad_oe), 64'd0);
      ifc_oe_b = 1'b1;
      ifc_cs   = 1'b1;
      wait_neg(3);
      rst_n = 1'b1;
      model_reset();
      wait_neg(4);
      chk("rst_mid_regq", reg_q, 64'd0);
      chk_state("rst_mid");
      bus_read(8'h40, 1'b0, '0, raw);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/ifc_mbox_slave.md
Name: ifc_mbox_slave

Overview:
- Parametrised IFC local-bus slave for the CPLD. Successor to the fixed single-register IFC decode.
- Samples the asynchronous IFC strobes on the system clock and latches the address on AVD.
- Provides NREG read/write control registers, a status/command register and a FIFO-backed block-read data port with pop-on-read.
- Sits between the IFC pins (top-level tristate) and the CPLD data producers (UART/FPGA handshake logic).

Parameters:
- DW, 16: IFC data width.
- AW, 8: latched address width.
- NREG, 4: number of control registers, at BASE_CTRL..BASE_CTRL+NREG-1.
- BASE_CTRL, 8'h10: first control register address.
- ADDR_STAT, 8'h40: status/command register address.
- ADDR_DATA, 8'h54: FIFO data port address.
- FIFO_AW, 4: FIFO depth is 2**FIFO_AW words.
- IRQ_LEVEL, 5: fill level at which irq asserts.
- BIT_REV, 1: 1 = IFC bit order reversed (bus bit 0 = MSB) on both address and data.

Ports:
- clock_50MHz  in  1  system clock.
- rst_n  in  1  asynchronous reset, active low.
- ifc_cs  in  1  chip select, active low.
- ifc_we_b  in  1  write strobe, active low.
- ifc_oe_b  in  1  output enable, active low.
- ifc_avd  in  1  address valid, active high.
- ifc_addr  in  AW  externally latched address, bus bit order.
- ifc_ad_i  in  DW  AD bus input.
- ifc_ad_o  out  DW  AD bus drive value.
- ifc_ad_oe  out  1  AD bus drive enable; top level tristates when 0.
- fill_data  in  DW  FIFO push data.
- fill_valid  in  1  push request.
- fill_ready  out  1  FIFO not full.
- reg_q  out  NREG*DW  control register contents; reg k occupies [k*DW +: DW].
- reg_wr  out  NREG  one-cycle pulse per register written.
- blk_req  out  1  one-cycle block-request pulse.
- fifo_cnt  out  FIFO_AW+1  FIFO fill level.
- irq  out  1  level interrupt.

Behaviour:
- Reset (async, rst_n=0): all outputs 0, reg_q=0, FIFO empty, sticky flags 0, address latch 0.
- Reset mid-transaction: ifc_ad_oe drops immediately. No commit or pop occurs for the interrupted access.
- Synchronisers: ifc_cs, ifc_we_b, ifc_oe_b and ifc_avd each pass through 2-FF synchronisers; a third stage provides edge detection. ifc_ad_i is registered each clock.
- Address: on synced avd 1->0, the latch captures ifc_addr, bit-reversed when BIT_REV=1. This is the decoded address A.
- Write commit: on synced we_b 0->1 where cs was low in the prior synced sample (cs may rise in the same bus edge as we_b).
  - Data = last registered ifc_ad_i sampled while we_b low, bit-reversed if BIT_REV.
  - A in control range: reg k <= data; reg_wr[k] pulses one clock.
  - A=ADDR_STAT: bit0=1 pulses blk_req; bit1=1 clears the sticky flags; bit2=1 flushes the FIFO (count=0).
  - A=ADDR_DATA or unmapped: ignored.
- Read: while synced cs=0 and oe_b=0, ifc_ad_oe=1.
  - ifc_ad_o is latched on the first synced cycle of the read and held stable until oe deasserts.
  - Drive latency is 2-3 clocks after the pin edge.
  - Read mux (bit-reversed if BIT_REV): control regs; ADDR_STAT = {ovf, unf, zero pad, fifo_cnt}, with ovf at DW-1 and unf at DW-2; ADDR_DATA = FIFO head, or 0 if empty; unmapped = 0.
  - ifc_ad_oe drops the cycle after synced oe_b or cs rises.
- Pop: on synced oe_b 0->1 with prior cs low and A=ADDR_DATA, the FIFO pops one word.
  - Pop when empty: no change; unf sticky set.
- FIFO push: fill_valid && fill_ready writes fill_data. fill_ready = (fifo_cnt < 2**FIFO_AW).
  - fill_valid while full: data dropped, ovf sticky set.
  - Simultaneous push and pop: both occur and the count is unchanged; allowed when full.
  - Flush and push in the same cycle: flush wins, push discarded, ovf not set.
  - Pointers wrap modulo 2**FIFO_AW.
- irq = (fifo_cnt >= IRQ_LEVEL) | ovf | unf, registered.
- Command write and status read are independent; a status read never clears flags.

Test Plan:
- Reset, then read ADDR_STAT (A=0x40, bus addr 8'h02) -> ifc_ad_o=0, irq=0, ifc_ad_oe=0 after oe_b/cs rise.
- Write 16'h0123 (bus value bit-reversed, 16'hC480) to 0x11 -> reg_wr=4'b0010 for 1 clock; reg_q[31:16]=16'h0123; read-back of 0x11 drives 16'hC480.
- Write 0x40 data 1 -> blk_req one-clock pulse. Push 5 words 0x1000..0x1004 -> irq=1, fifo_cnt=5. Five reads of 0x54 return 0x1000..0x1004 in order -> fifo_cnt=0, irq=0.
- Read 0x54 when empty -> returns 0, unf=1, irq=1. Write 0x40 data 2 -> unf=0, irq=0.
- Fill 16 words, push a 17th -> fill_ready=0, 17th dropped, ovf=1. Write 0x40 data 4 -> fifo_cnt=0 and ovf remains 1. Push and pop in the same cycle at full -> fifo_cnt stays 16.
- Drop rst_n during a read with ifc_ad_oe=1 -> ifc_ad_oe=0 asynchronously; no pop; reg_q=0 after release.
